// File: rtl/debounce_filter.sv
// Debounce filter: 2-flop synchronizer feeding a 4-state qualification FSM.
// The filtered level follows the input only after STABLE_CYCLES matching samples.
//
// state      | meaning
// ST_LOW     | accepted level 0, idle
// ST_PEND_HI | synchronized input is 1, qualifying a rise
// ST_HIGH    | accepted level 1, idle
// ST_PEND_LO | synchronized input is 0, qualifying a fall
module debounce_filter #(
    parameter int STABLE_CYCLES = 4,
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    output logic a_clean,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_bad_param
        $error("debounce_filter: STABLE_CYCLES must be in 2..65535");
    end

    localparam logic [1:0] ST_LOW     = 2'd0;
    localparam logic [1:0] ST_PEND_HI = 2'd1;
    localparam logic [1:0] ST_HIGH    = 2'd2;
    localparam logic [1:0] ST_PEND_LO = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= ST_LOW;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= a_raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                ST_LOW: begin
                    if (s2) begin
                        state <= ST_PEND_HI;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_PEND_HI: begin
                    if (!s2) begin
                        state <= ST_LOW;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!s2) begin
                        state <= ST_PEND_LO;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_PEND_LO: begin
                    if (s2) begin
                        state <= ST_HIGH;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= ST_LOW;
                        cnt   <= '0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Outputs decode straight from the state register, so they are glitch-free.
    assign a_clean = (state == ST_HIGH) || (state == ST_PEND_LO);
    assign busy    = (state == ST_PEND_HI) || (state == ST_PEND_LO);

endmodule

// File: tb/tb_debounce_filter.sv
// Bench for debounce_filter: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed edge-by-edge expectations.
module tb_debounce_filter;

    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a_raw = 1'b0;
    logic a_clean, rise, fall, busy;

    int total = 0;
    int bad = 0;

    debounce_filter #(.STABLE_CYCLES(STABLE)) dut (
        .clk(clk),
        .rst(rst),
        .a_raw(a_raw),
        .a_clean(a_clean),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b, want %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a delay line of raw samples, plus a count of how many
    // consecutive delayed samples disagree with the accepted level.
    logic m_pipe [2];
    logic m_level;
    int   m_run;
    logic m_rise, m_fall;
    logic m_valid = 1'b0;
    logic saw_change = 1'b0;

    always @(posedge clk) begin
        logic samp;
        if (rst) begin
            m_pipe[0] = 1'b0;
            m_pipe[1] = 1'b0;
            m_level   = 1'b0;
            m_run     = 0;
            m_rise    = 1'b0;
            m_fall    = 1'b0;
            m_valid   = 1'b1;
        end else if (m_valid) begin
            samp      = m_pipe[1];
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = a_raw;
            m_rise    = 1'b0;
            m_fall    = 1'b0;
            if (samp != m_level) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_level = samp;
                    m_run   = 0;
                    if (samp) m_rise = 1'b1;
                    else      m_fall = 1'b1;
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
        if (m_valid) begin
            chk("model_a_clean", a_clean, m_level);
            chk("model_rise", rise, m_rise);
            chk("model_fall", fall, m_fall);
            chk("model_busy", busy, m_run > 0);
            if (a_clean !== 1'b0) saw_change = 1'b1;
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset with a_raw toggling; outputs must stay at reset values
        a_raw = 1'b1;
        rst   = 1'b1;
        wait_neg(1);
        a_raw = 1'b0;
        wait_neg(1);
        a_raw = 1'b1;
        wait_neg(1);
        chk("reset_a_clean", a_clean, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_rise", rise, 1'b0);
        a_raw = 1'b0;
        rst   = 1'b0;

        // steady low
        wait_neg(20);
        chk("idle_a_clean", a_clean, 1'b0);
        chk("idle_busy", busy, 1'b0);

        // clean rise: a_raw set before edge N; now at negedge after N-1
        a_raw = 1'b1;
        wait_neg(2);                       // after N+1
        chk("rise_busy_n1", busy, 1'b0);
        wait_neg(1);                       // after N+2
        chk("rise_busy_n2", busy, 1'b1);
        chk("rise_clean_n2", a_clean, 1'b0);
        wait_neg(2);                       // after N+4
        chk("rise_clean_n4", a_clean, 1'b0);
        chk("rise_pulse_n4", rise, 1'b0);
        wait_neg(1);                       // after N+5
        chk("rise_clean_n5", a_clean, 1'b1);
        chk("rise_pulse_n5", rise, 1'b1);
        chk("rise_busy_n5", busy, 1'b0);
        wait_neg(1);                       // after N+6
        chk("rise_pulse_n6", rise, 1'b0);
        wait_neg(3);

        // clean fall from edge M
        a_raw = 1'b0;
        wait_neg(5);                       // after M+4
        chk("fall_clean_m4", a_clean, 1'b1);
        chk("fall_pulse_m4", fall, 1'b0);
        wait_neg(1);                       // after M+5
        chk("fall_clean_m5", a_clean, 1'b0);
        chk("fall_pulse_m5", fall, 1'b1);
        chk("fall_rise_m5", rise, 1'b0);
        wait_neg(1);
        chk("fall_pulse_m6", fall, 1'b0);
        wait_neg(5);

        // 3-cycle glitch: busy pulses, no change
        a_raw = 1'b1;
        wait_neg(3);
        a_raw = 1'b0;
        chk("glitch_busy", busy, 1'b1);
        wait_neg(8);
        chk("glitch_clean", a_clean, 1'b0);
        chk("glitch_busy_end", busy, 1'b0);

        // high 3, low 1, high held: counting restarts from the final 0->1
        a_raw = 1'b1;
        wait_neg(3);
        a_raw = 1'b0;
        wait_neg(1);
        a_raw = 1'b1;                      // final rise before edge N
        wait_neg(5);                       // after N+4
        chk("restart_clean_n4", a_clean, 1'b0);
        chk("restart_rise_n4", rise, 1'b0);
        wait_neg(1);                       // after N+5
        chk("restart_clean_n5", a_clean, 1'b1);
        chk("restart_rise_n5", rise, 1'b1);
        wait_neg(3);

        // reset while HIGH with a_raw held at 1
        rst = 1'b1;                        // sampled at edge R
        wait_neg(1);
        chk("rst_high_clean", a_clean, 1'b0);
        chk("rst_high_fall", fall, 1'b0);
        rst = 1'b0;
        wait_neg(5);                       // after R+5
        chk("rst_requal_clean_r5", a_clean, 1'b0);
        chk("rst_requal_busy_r5", busy, 1'b1);
        wait_neg(1);                       // after R+6
        chk("rst_requal_clean_r6", a_clean, 1'b1);
        chk("rst_requal_rise_r6", rise, 1'b1);
        wait_neg(2);

        // back to low, then toggle every cycle for 50 cycles
        a_raw = 1'b0;
        wait_neg(10);
        chk("pre_toggle_clean", a_clean, 1'b0);
        saw_change = 1'b0;
        for (int i = 0; i < 50; i++) begin
            a_raw = ~a_raw;
            wait_neg(1);
        end
        a_raw = 1'b0;
        wait_neg(4);
        chk("toggle_never_high", saw_change, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/debounce_filter.md
Name: debounce_filter

Overview:
Conditions a raw asynchronous level input (button, external strobe) before it reaches the edge and pulse detectors. A 2-flop synchronizer feeds a 4-state filter FSM. The filtered level changes only after the synchronized input has held the new value for STABLE_CYCLES consecutive samples. The block also emits registered one-cycle rise and fall pulses, so downstream detectors see a clean, glitch-free signal.

Parameters:
STABLE_CYCLES, 4, consecutive synchronized samples required to accept a level change; legal range 2..65535; elaboration error outside this range
CNT_W, $clog2(STABLE_CYCLES+1), counter width; derived, not overridden

Ports:
clk  input  1  single clock; all state updates on posedge clk
rst  input  1  synchronous, active-high reset
a_raw  input  1  raw asynchronous level input
a_clean  output  1  filtered level, registered
rise  output  1  one-cycle pulse, high in the same cycle a_clean first reads 1
fall  output  1  one-cycle pulse, high in the same cycle a_clean first reads 0
busy  output  1  high while a candidate level change is being qualified (pending states)

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values (rst sampled high at a posedge): sync flops s1 and s2 = 0, state = LOW, cnt = 0, a_clean = 0, rise = 0, fall = 0, busy = 0. These hold every cycle rst is high, whatever a_raw does.
- Synchronizer: s1 <= a_raw; s2 <= s1. The FSM sees a_sync = s2 only, never a_raw directly.
- FSM states: LOW, PEND_HIGH, HIGH, PEND_LOW.
  - a_clean = 1 in HIGH and PEND_LOW; a_clean = 0 in LOW and PEND_HIGH.
  - busy = 1 in PEND_HIGH and PEND_LOW only.
- Transitions, evaluated at each posedge:
  - LOW: a_sync = 1 -> PEND_HIGH, cnt <= 1. Otherwise stay in LOW, cnt <= 0.
  - PEND_HIGH: a_sync = 0 -> LOW, cnt <= 0 (glitch rejected, no pulse). a_sync = 1 and cnt = STABLE_CYCLES-1 -> HIGH, cnt <= 0, rise <= 1. Otherwise cnt <= cnt+1.
  - HIGH and PEND_LOW: mirror of LOW and PEND_HIGH with polarity inverted; fall replaces rise.
- rise and fall default to 0 every cycle unless set by the qualifying transition. Each is high for exactly one cycle. They are never both high.
- Latency: if a_raw = 1 is set up before posedge N and held, a_clean reads 1 after posedge N+STABLE_CYCLES+1 (N+5 at default). rise is high in that same cycle. Falling latency is symmetric.
- Glitch rejection:
  - A synchronized pulse shorter than STABLE_CYCLES samples produces no change on a_clean, rise or fall.
  - Any return to the accepted level during a pending state aborts qualification. The next departure restarts counting at 1; there is no partial credit.
- Counter: cnt never exceeds STABLE_CYCLES-1 and never wraps.
- Reset mid-qualification or while HIGH: the next cycle is LOW with a_clean = 0 and no fall pulse. If a_raw is still 1 after rst is released, a full qualification follows, giving a_clean = 1 STABLE_CYCLES+1 edges after the first non-reset edge.
- a_raw toggling every cycle: a_clean never changes; busy may toggle.

Test Plan:
- Reset then steady a_raw = 0 for 20 cycles -> a_clean = 0, rise = fall = busy = 0 throughout.
- a_raw 0->1 before posedge N, held -> busy high from after N+2; a_clean = 1 and rise = 1 after N+5; rise = 0 after N+6; a_raw back to 0 at posedge M -> fall = 1 and a_clean = 0 after M+5.
- a_raw high for 3 cycles, then 0 -> busy pulses high; a_clean, rise and fall stay 0 for the whole run.
- a_raw high 3 cycles, low 1, high held -> no rise at the first attempt; rise occurs 5 edges after the final 0->1, confirming the counter restart.
- a_raw = 1 qualified (a_clean = 1), then rst high for 1 cycle with a_raw still 1 -> a_clean = 0, no fall pulse; a_clean = 1 with rise exactly 5 edges after rst is released.
- a_raw toggling every cycle for 50 cycles starting from LOW -> a_clean = 0, rise = fall = 0 throughout.
